// File: rtl/fpu_sequencer.sv
// Multi-cycle FPU issue sequencer: holds the pipeline while an add/mul/div/sqrt
// unit runs, steers the result mux and flags the result for EX_MEM capture.
//
// state | meaning
// IDLE  | no FPU op in flight; a multi-cycle op in EX issues here
// RUN   | selected unit executing; counter counts down to zero
// DONE  | result valid for one cycle; held instruction leaves EX
module fpu_sequencer #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        fpu_sel,
  input  logic [3:0]  fpu_op,
  input  logic        flush,
  output logic        fpu_inprogress,
  output logic [3:0]  unit_start,
  output logic [3:0]  active_unit,
  output logic        result_valid,
  output logic [15:0] stall_count,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  localparam logic [CNT_W-1:0] LOAD_ADD  = CNT_W'(LAT_ADD - 1);
  localparam logic [CNT_W-1:0] LOAD_MUL  = CNT_W'(LAT_MUL - 1);
  localparam logic [CNT_W-1:0] LOAD_DIV  = CNT_W'(LAT_DIV - 1);
  localparam logic [CNT_W-1:0] LOAD_SQRT = CNT_W'(LAT_SQRT - 1);

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] issueLoad;
  logic [3:0]       issueUnit;
  logic [3:0]       activeNext;
  logic [3:0]       startNext;
  logic             issue;

  // Only 4'b10xx is multi-cycle; everything else completes in EX.
  always_comb begin
    issue     = fpu_sel && (fpu_op[3:2] == 2'b10);
    issueUnit = 4'b0001 << fpu_op[1:0];
    case (fpu_op[1:0])
      2'b00:   issueLoad = LOAD_ADD;
      2'b01:   issueLoad = LOAD_MUL;
      2'b10:   issueLoad = LOAD_DIV;
      default: issueLoad = LOAD_SQRT;
    endcase
  end

  always_comb begin
    stateNext      = state;
    cntNext        = cnt;
    activeNext     = active_unit;
    startNext      = 4'b0000;
    fpu_inprogress = 1'b0;
    result_valid   = 1'b0;
    case (state)
      IDLE: begin
        activeNext = 4'b0000;
        if (issue) begin
          fpu_inprogress = 1'b1;
          stateNext      = RUN;
          cntNext        = issueLoad;
          activeNext     = issueUnit;
          startNext      = issueUnit;
        end
      end
      RUN: begin
        fpu_inprogress = 1'b1;
        if (cnt == '0) stateNext = DONE;
        else           cntNext   = cnt - 1'b1;
      end
      DONE: begin
        // The held instruction is still in EX here, so fpu_sel is ignored.
        result_valid = 1'b1;
        stateNext    = IDLE;
        activeNext   = 4'b0000;
      end
      default: begin
        stateNext  = IDLE;
        cntNext    = '0;
        activeNext = 4'b0000;
      end
    endcase
    if (flush) begin
      stateNext      = IDLE;
      cntNext        = '0;
      activeNext     = 4'b0000;
      startNext      = 4'b0000;
      fpu_inprogress = 1'b0;
      result_valid   = 1'b0;
    end
    // Hold must drop the moment clear rises, before any clock edge.
    if (clear) fpu_inprogress = 1'b0;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      cnt         <= '0;
      active_unit <= 4'b0000;
      unit_start  <= 4'b0000;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      active_unit <= activeNext;
      unit_start  <= startNext;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      stall_count <= 16'h0000;
      op_count    <= 16'h0000;
    end else begin
      if (fpu_inprogress && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'h0001;
      if (result_valid)
        op_count <= op_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer: an issue-time based model checked every
// cycle, plus literal expectations for each scenario.
module tb_fpu_sequencer;

  localparam int L_ADD = 3, L_MUL = 4, L_DIV = 16, L_SQRT = 16;

  logic        clock, clear, fpuSel, flushIn;
  logic [3:0]  fpuOp;
  logic        fpuInprogress, resultValid;
  logic [3:0]  unitStart, activeUnit;
  logic [15:0] stallCount, opCount;

  int vectors = 0;
  int miscompares = 0;

  fpu_sequencer dut (
    .clock(clock), .clear(clear), .fpu_sel(fpuSel), .fpu_op(fpuOp),
    .flush(flushIn), .fpu_inprogress(fpuInprogress), .unit_start(unitStart),
    .active_unit(activeUnit), .result_valid(resultValid),
    .stall_count(stallCount), .op_count(opCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int latOf(input logic [1:0] u);
    case (u)
      2'b00:   return L_ADD;
      2'b01:   return L_MUL;
      2'b10:   return L_DIV;
      default: return L_SQRT;
    endcase
  endfunction

  // Model: an op issued at cycle t runs in cycles t+1..t+L and is done at t+L+1.
  initial begin
    int cyc = 0, issueCyc = 0, lat = 0, mStall = 0, mOps = 0, k;
    bit busy = 0, endNow, startNow;
    logic [3:0] unit = 4'b0, eStart, eActive;
    logic eInprog, eRv;
    forever begin
      @(negedge clock);
      cyc++;
      if (clear) begin
        busy = 0; mStall = 0; mOps = 0;
        chk("rst_inprogress", {31'b0, fpuInprogress}, 32'd0);
        chk("rst_unit_start", {28'b0, unitStart}, 32'd0);
        chk("rst_active_unit", {28'b0, activeUnit}, 32'd0);
        chk("rst_result_valid", {31'b0, resultValid}, 32'd0);
        chk("rst_stall_count", {16'b0, stallCount}, 32'd0);
        chk("rst_op_count", {16'b0, opCount}, 32'd0);
      end else begin
        eInprog = 0; eStart = 4'b0; eActive = 4'b0; eRv = 0;
        endNow = 0; startNow = 0;
        if (!busy) begin
          if (fpuSel && fpuOp[3:2] == 2'b10 && !flushIn) begin
            eInprog = 1; startNow = 1;
          end
        end else begin
          k = cyc - issueCyc;
          eActive = unit;
          if (k <= lat) begin
            eInprog = !flushIn;
            eStart = (k == 1) ? unit : 4'b0;
          end else begin
            eRv = !flushIn;
          end
          endNow = flushIn || (k > lat);
        end
        chk("m_inprogress", {31'b0, fpuInprogress}, {31'b0, eInprog});
        chk("m_unit_start", {28'b0, unitStart}, {28'b0, eStart});
        chk("m_active_unit", {28'b0, activeUnit}, {28'b0, eActive});
        chk("m_result_valid", {31'b0, resultValid}, {31'b0, eRv});
        chk("m_stall_count", {16'b0, stallCount}, mStall);
        chk("m_op_count", {16'b0, opCount}, mOps);
        if (eInprog && mStall < 65535) mStall++;
        if (eRv) mOps = (mOps + 1) & 16'hFFFF;
        if (endNow) busy = 0;
        if (startNow) begin
          busy = 1; issueCyc = cyc; lat = latOf(fpuOp[1:0]);
          unit = 4'b0001 << fpuOp[1:0];
        end
      end
    end
  end

  task automatic drive(input logic sel, input logic [3:0] op, input logic fl);
    @(posedge clock); #1;
    fpuSel = sel; fpuOp = op; flushIn = fl;
    @(negedge clock); #1;
  endtask

  task automatic doClear();
    clear = 1'b1; fpuSel = 1'b0; flushIn = 1'b0;
    @(negedge clock); #1;
    clear = 1'b0;
  endtask

  initial begin
    int nIn;
    clear = 1'b1; fpuSel = 1'b0; fpuOp = 4'b0; flushIn = 1'b0;
    @(negedge clock); #1;
    clear = 1'b0;

    // Add with default latency
    doClear();
    for (int c = 0; c <= 4; c++) begin
      drive(1'b1, 4'b1000, 1'b0);
      if (c == 0) chk("add_inprog_c0", {31'b0, fpuInprogress}, 32'd1);
      if (c == 1) chk("add_start_c1", {28'b0, unitStart}, 32'h1);
      if (c == 3) chk("add_inprog_c3", {31'b0, fpuInprogress}, 32'd1);
      if (c == 4) begin
        chk("add_rv_c4", {31'b0, resultValid}, 32'd1);
        chk("add_inprog_c4", {31'b0, fpuInprogress}, 32'd0);
      end
    end
    drive(1'b0, 4'b0000, 1'b0);
    chk("add_stall", {16'b0, stallCount}, 32'd4);
    chk("add_ops", {16'b0, opCount}, 32'd1);

    // Divide, then single-cycle ops leave counters alone
    doClear();
    nIn = 0;
    for (int c = 0; c <= 17; c++) begin
      drive(1'b1, 4'b1010, 1'b0);
      nIn += int'(fpuInprogress);
      if (c == 1) chk("div_start_c1", {28'b0, unitStart}, 32'h4);
      if (c == 1 || c == 9 || c == 17) chk("div_active", {28'b0, activeUnit}, 32'h4);
      if (c == 17) chk("div_rv_c17", {31'b0, resultValid}, 32'd1);
    end
    chk("div_stall_cycles", nIn, 32'd17);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b1100, 1'b0);
      chk("single_inprog", {31'b0, fpuInprogress}, 32'd0);
      chk("single_rv", {31'b0, resultValid}, 32'd0);
    end
    chk("single_stall", {16'b0, stallCount}, 32'd17);
    chk("single_ops", {16'b0, opCount}, 32'd1);

    // Flush during multiply
    doClear();
    drive(1'b1, 4'b1001, 1'b0);
    drive(1'b1, 4'b1001, 1'b0);
    drive(1'b1, 4'b1001, 1'b1);
    chk("flush_inprog_c2", {31'b0, fpuInprogress}, 32'd0);
    drive(1'b0, 4'b0000, 1'b0);
    chk("flush_active_c3", {28'b0, activeUnit}, 32'h0);
    chk("flush_rv_c3", {31'b0, resultValid}, 32'd0);
    chk("flush_stall", {16'b0, stallCount}, 32'd2);
    for (int c = 0; c < 4; c++) drive(1'b0, 4'b0000, 1'b0);
    chk("flush_ops", {16'b0, opCount}, 32'd0);

    // Clear asserted mid-sqrt, between clock edges
    doClear();
    for (int c = 0; c <= 3; c++) drive(1'b1, 4'b1011, 1'b0);
    clear = 1'b1;
    #1;
    chk("clr_inprog", {31'b0, fpuInprogress}, 32'd0);
    chk("clr_active", {28'b0, activeUnit}, 32'h0);
    chk("clr_stall", {16'b0, stallCount}, 32'd0);
    fpuSel = 1'b0;
    @(negedge clock); #1;
    clear = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      drive(1'b1, 4'b1000, 1'b0);
      if (c == 1) chk("post_clr_start", {28'b0, unitStart}, 32'h1);
      if (c == 4) chk("post_clr_rv", {31'b0, resultValid}, 32'd1);
    end
    drive(1'b0, 4'b0000, 1'b0);
    chk("post_clr_stall", {16'b0, stallCount}, 32'd4);

    // Back-to-back add then mul
    doClear();
    for (int c = 0; c <= 4; c++) begin
      drive(1'b1, 4'b1000, 1'b0);
      if (c == 4) chk("b2b_rv_c4", {31'b0, resultValid}, 32'd1);
    end
    for (int c = 5; c <= 10; c++) begin
      drive(1'b1, 4'b1001, 1'b0);
      if (c == 5) chk("b2b_issue_c5", {31'b0, fpuInprogress}, 32'd1);
      if (c == 6) chk("b2b_start_c6", {28'b0, unitStart}, 32'h2);
      if (c == 10) chk("b2b_rv_c10", {31'b0, resultValid}, 32'd1);
    end
    drive(1'b0, 4'b0000, 1'b0);
    chk("b2b_ops", {16'b0, opCount}, 32'd2);
    chk("b2b_stall", {16'b0, stallCount}, 32'd9);

    drive(1'b0, 4'b0000, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_sequencer.md
FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 The block SHALL have parameter LAT_ADD, default 3, execute cycles for FP add/sub.
REQ-002 The block SHALL have parameter LAT_MUL, default 4, execute cycles for FP multiply.
REQ-003 The block SHALL have parameter LAT_DIV, default 16, execute cycles for FP divide.
REQ-004 The block SHALL have parameter LAT_SQRT, default 16, execute cycles for FP square root.
REQ-005 The block SHALL have parameter CNT_W, default 5, latency counter width; every LAT_* SHALL lie in 1..2^CNT_W.
REQ-006 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port clear, input, 1, reset, asynchronous and active-high.
REQ-008 The block SHALL have port fpu_sel, input, 1, high when the EX-stage instruction uses the FPU result.
REQ-009 The block SHALL have port fpu_op, input, 4, the EX-stage {fpuOp, aluOp} code.
REQ-010 The block SHALL have port flush, input, 1, synchronous abort of the in-flight FPU operation.
REQ-011 The block SHALL have port fpu_inprogress, output, 1, pipeline hold to the PC, IF_ID, ID_EX, EX_MEM and MEM_WB enables.
REQ-012 The block SHALL have port unit_start, output, 4, one-hot start pulse: bit0 add, bit1 mul, bit2 div, bit3 sqrt.
REQ-013 The block SHALL have port active_unit, output, 4, one-hot unit owning the FPU result mux.
REQ-014 The block SHALL have port result_valid, output, 1, FPU result valid for EX_MEM capture.
REQ-015 The block SHALL have port stall_count, output, 16, number of cycles with fpu_inprogress high.
REQ-016 The block SHALL have port op_count, output, 16, number of completed multi-cycle operations.

Function
REQ-017 fpu_op decoding SHALL be: 4'b1000 add/sub, 4'b1001 mul, 4'b1010 div, 4'b1011 sqrt (the multi-cycle ops); 4'b11xx and every code with bit3=0 SHALL be single-cycle.
REQ-018 A single-cycle op, or fpu_sel=0, SHALL produce no stall, no unit_start and no result_valid.
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 IDLE SHALL go to RUN when fpu_sel=1 and a multi-cycle op is present (the issue cycle); the counter SHALL load LAT_x-1 and the unit SHALL be latched into active_unit.
REQ-021 RUN SHALL decrement the counter each cycle and SHALL go to DONE in the cycle after the counter reads 0, so RUN lasts exactly LAT_x cycles.
REQ-022 DONE SHALL last one cycle and SHALL then return to IDLE; fpu_sel/fpu_op SHALL be ignored in DONE, so the held instruction does not re-issue.
REQ-023 fpu_inprogress SHALL be combinational: high when (IDLE and issue condition) or RUN, and low when flush=1.
REQ-024 Total stall per op SHALL be LAT_x+1 cycles: the issue cycle plus LAT_x RUN cycles; the instruction leaves EX at the end of the DONE cycle.
REQ-025 unit_start SHALL be registered and high for exactly the first RUN cycle only.
REQ-026 active_unit SHALL be valid in RUN and DONE, and 0 in IDLE.
REQ-027 result_valid SHALL be high only in DONE.
REQ-028 flush SHALL have priority over all other transitions: next state IDLE, counter cleared, active_unit cleared, no DONE, no result_valid, op_count unchanged.
REQ-029 stall_count SHALL increment in every cycle with fpu_inprogress=1 and SHALL saturate at 16'hFFFF.
REQ-030 op_count SHALL increment in each DONE cycle and SHALL wrap from 16'hFFFF to 0.
REQ-031 Back-to-back ops SHALL be supported: a multi-cycle op in EX in the cycle after DONE SHALL issue from IDLE with no bubble.
REQ-032 With LAT_x=1 the sequence SHALL be issue, one RUN cycle, then DONE.

Reset
REQ-033 clear=1 SHALL force, asynchronously, state IDLE, counter 0, unit_start 0, active_unit 0, result_valid 0, stall_count 0 and op_count 0.
REQ-034 fpu_inprogress SHALL be 0 while clear=1, including when clear is asserted mid-RUN.
REQ-035 After clear is released the first issue SHALL behave exactly as in REQ-020.

Verification
REQ-036 Add, defaults: fpu_sel=1, fpu_op=4'b1000 at cycle 0 -> fpu_inprogress high cycles 0-3; unit_start=4'b0001 at cycle 1; result_valid at cycle 4; stall_count=4; op_count=1.
REQ-037 Div: fpu_op=4'b1010 -> 17 stall cycles; unit_start=4'b0100 at cycle 1; result_valid at cycle 17; active_unit=4'b0100 in cycles 1-17.
REQ-038 Single-cycle: fpu_sel=1, fpu_op=4'b1100 -> fpu_inprogress, unit_start and result_valid stay 0; both counters unchanged.
REQ-039 Flush: mul issued at cycle 0, flush=1 at cycle 2 -> fpu_inprogress 0 in cycle 2; IDLE at cycle 3; no result_valid; op_count unchanged; stall_count=2.
REQ-040 Reset mid-op: clear=1 during RUN of a sqrt -> all outputs 0 immediately, without waiting for a clock edge.
REQ-041 Back-to-back: add then mul in consecutive EX slots -> result_valid at cycle 4; mul issue at cycle 5; result_valid at cycle 10; op_count=2.
